// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch redirect unit: word width, opcodes,
// bubble encoding and a small PC arithmetic helper.
package fetch_redirect_unit_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   // Bubble encoding written into IF/ID on squash and reset
   localparam word_t NOP_WORD = 16'hFFFF;

   // Redirecting opcodes as seen by the decode stage
   typedef enum logic [3:0] {
      OP_BEQ  = 4'd8,
      OP_BNE  = 4'd9,
      OP_JMP  = 4'd10,
      OP_CALL = 4'd11,
      OP_RET  = 4'd12,
      OP_FOR  = 4'd13
   } opcode_e;

   // Sequential successor of a word address, wrapping at the top of memory
   function automatic word_t word_inc(input word_t w);
      return w + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Bus between the fetch redirect unit, the decode/hazard logic and
// instruction memory.
interface fetch_redirect_unit_if;
   import fetch_redirect_unit_pkg::*;

   logic       kill;
   logic [3:0] op_id;
   word_t      imm_id;
   word_t      jump_target;
   word_t      for_target;
   logic       stall;
   word_t      instr_mem;
   word_t      pc;
   word_t      if_id_instr;
   word_t      if_id_pc;
   logic       if_id_valid;
   logic       ras_overflow;
   logic       ras_underflow;

   modport slave (
      input  kill, op_id, imm_id, jump_target, for_target, stall, instr_mem,
      output pc, if_id_instr, if_id_pc, if_id_valid, ras_overflow, ras_underflow
   );

   modport master (
      output kill, op_id, imm_id, jump_target, for_target, stall, instr_mem,
      input  pc, if_id_instr, if_id_pc, if_id_valid, ras_overflow, ras_underflow
   );

endinterface

// File: rtl/fetch_redirect_unit_return_addr_stack.sv
// Return-address LIFO. A push while full or a pop while empty is ignored;
// the caller decides how to flag it.
module return_addr_stack
   import fetch_redirect_unit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  push,
   input  logic  pop,
   input  word_t push_data,
   output word_t top,
   output logic  full,
   output logic  empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] ONE_PTR  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CW-1:0] cnt_q, cnt_d;
   word_t         mem_q [DEPTH];
   word_t         mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_s;

   assign wr_ptr_s = cnt_q[PW-1:0];
   assign full     = (cnt_q == FULL_CNT);
   assign empty    = (cnt_q == {CW{1'b0}});
   assign top      = mem_q[wr_ptr_s - ONE_PTR];

   // Next stack contents and occupancy for one push or one pop
   always_comb begin
      cnt_d = cnt_q;
      mem_d = mem_q;
      if (push && !full) begin
         mem_d[wr_ptr_s] = push_data;
         cnt_d           = cnt_q + ONE_CNT;
      end else if (pop && !empty) begin
         cnt_d = cnt_q - ONE_CNT;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Occupancy resets to empty; entry storage needs no reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-side redirect handling: PC register, IF/ID register and the
// return-address stack updated by CALL/RET redirects.
module fetch_redirect_unit
   import fetch_redirect_unit_pkg::*;
#(
   parameter int    RAS_DEPTH = 8,
   parameter word_t RESET_PC  = 16'h0000,
   parameter word_t NOP_INSTR = NOP_WORD
) (
   input  logic                  CLK,
   input  logic                  RST,
   fetch_redirect_unit_if.slave  bus
);

   word_t pc_q, pc_d;
   word_t if_id_instr_q, if_id_instr_d;
   word_t if_id_pc_q, if_id_pc_d;
   logic  if_id_valid_q, if_id_valid_d;
   logic  ras_ovf_q, ras_ovf_d;
   logic  ras_unf_q, ras_unf_d;

   logic  redir_s;
   logic  push_s, pop_s;
   word_t target_s;
   word_t ras_top_s;
   logic  ras_full_s, ras_empty_s;

   // A kill aimed at a bubble is ignored so a held kill squashes only once
   assign redir_s = bus.kill & if_id_valid_q;

   return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (word_inc(if_id_pc_q)),
      .top       (ras_top_s),
      .full      (ras_full_s),
      .empty     (ras_empty_s)
   );

   // Next-PC select and IF/ID update: redirect beats stall beats sequential fetch
   always_comb begin
      pc_d          = pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_valid_d = if_id_valid_q;
      ras_ovf_d     = ras_ovf_q;
      ras_unf_d     = ras_unf_q;
      push_s        = 1'b0;
      pop_s         = 1'b0;
      target_s      = word_inc(if_id_pc_q);
      if (redir_s) begin
         case (bus.op_id)
            OP_BEQ, OP_BNE: target_s = if_id_pc_q + bus.imm_id;
            OP_JMP:         target_s = bus.jump_target;
            OP_CALL: begin
               target_s = bus.jump_target;
               if (ras_full_s) begin
                  ras_ovf_d = 1'b1;
               end else begin
                  push_s = 1'b1;
               end
            end
            OP_RET: begin
               if (ras_empty_s) begin
                  ras_unf_d = 1'b1;
               end else begin
                  target_s = ras_top_s;
                  pop_s    = 1'b1;
               end
            end
            OP_FOR:         target_s = bus.for_target;
            default:        target_s = word_inc(if_id_pc_q);
         endcase
         pc_d          = target_s;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
      end else if (bus.stall) begin
         pc_d          = pc_q;
         if_id_instr_d = if_id_instr_q;
         if_id_pc_d    = if_id_pc_q;
         if_id_valid_d = if_id_valid_q;
      end else begin
         pc_d          = word_inc(pc_q);
         if_id_instr_d = bus.instr_mem;
         if_id_pc_d    = pc_q;
         if_id_valid_d = 1'b1;
      end
   end

   // Fetch state registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q          <= RESET_PC;
         if_id_instr_q <= NOP_INSTR;
         if_id_pc_q    <= 16'h0000;
         if_id_valid_q <= 1'b0;
         ras_ovf_q     <= 1'b0;
         ras_unf_q     <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_valid_q <= if_id_valid_d;
         ras_ovf_q     <= ras_ovf_d;
         ras_unf_q     <= ras_unf_d;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.if_id_instr   = if_id_instr_q;
   assign bus.if_id_pc      = if_id_pc_q;
   assign bus.if_id_valid   = if_id_valid_q;
   assign bus.ras_overflow  = ras_ovf_q;
   assign bus.ras_underflow = ras_unf_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: a behavioural fetch model
// predicts the state after every clock; a monitor compares it.
module tb_fetch_redirect_unit;
   import fetch_redirect_unit_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   fetch_redirect_unit_if bus ();

   fetch_redirect_unit #(
      .RAS_DEPTH (8),
      .RESET_PC  (16'h0000),
      .NOP_INSTR (16'hFFFF)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Instruction memory: the word at address a is 16'h1000 + a
   assign bus.instr_mem = 16'h1000 + bus.pc;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] ipc;
      logic        v;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [15:0] m_pc, m_instr, m_ipc;
   logic        m_v, m_ovf, m_unf;
   logic [15:0] m_ras[$];

   // One clock of stimulus; the model predicts the post-edge state
   task automatic cyc(input logic r, input logic k, input logic [3:0] op,
                      input logic [15:0] imm, input logic [15:0] jt,
                      input logic [15:0] ft, input logic st);
      exp_t e;
      logic [15:0] tgt;
      @(negedge CLK);
      RST = r; bus.kill = k; bus.op_id = op; bus.imm_id = imm;
      bus.jump_target = jt; bus.for_target = ft; bus.stall = st;
      if (r) begin
         m_pc = 16'h0000; m_instr = 16'hFFFF; m_ipc = 16'h0000; m_v = 1'b0;
         m_ovf = 1'b0; m_unf = 1'b0; m_ras.delete();
      end else if (k && m_v) begin
         tgt = m_ipc + 16'd1;
         if (op == 4'd8 || op == 4'd9) tgt = m_ipc + imm;
         else if (op == 4'd10) tgt = jt;
         else if (op == 4'd13) tgt = ft;
         else if (op == 4'd11) begin
            tgt = jt;
            if (m_ras.size() >= 8) m_ovf = 1'b1;
            else m_ras.push_back(m_ipc + 16'd1);
         end else if (op == 4'd12) begin
            if (m_ras.size() == 0) m_unf = 1'b1;
            else tgt = m_ras.pop_back();
         end
         m_pc = tgt; m_instr = 16'hFFFF; m_v = 1'b0;
      end else if (!st) begin
         m_instr = 16'h1000 + m_pc; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 16'd1;
      end
      e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.v = m_v; e.ovf = m_ovf; e.unf = m_unf;
      exp_q.push_back(e);
   endtask

   task automatic norm();
      cyc(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
   endtask

   task automatic redir(input logic [3:0] op, input logic [15:0] imm,
                        input logic [15:0] jt, input logic st);
      cyc(1'b0, 1'b1, op, imm, jt, 16'h0000, st);
   endtask

   // Directed check against a literal, sampled just after the edge
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic settle();
      @(posedge CLK);
      #2;
   endtask

   // Monitor: pops one prediction per clock and compares all outputs
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.if_id_instr !== e.instr || bus.if_id_pc !== e.ipc ||
                bus.if_id_valid !== e.v || bus.ras_overflow !== e.ovf ||
                bus.ras_underflow !== e.unf) begin
               errors++;
               $display("FAIL state t=%0t actual pc=%h instr=%h ipc=%h v=%b ovf=%b unf=%b required pc=%h instr=%h ipc=%h v=%b ovf=%b unf=%b",
                        $time, bus.pc, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid,
                        bus.ras_overflow, bus.ras_underflow,
                        e.pc, e.instr, e.ipc, e.v, e.ovf, e.unf);
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by random traffic
   initial begin
      RST = 1'b1; bus.kill = 1'b0; bus.op_id = 4'd0; bus.imm_id = 16'h0000;
      bus.jump_target = 16'h0000; bus.for_target = 16'h0000; bus.stall = 1'b0;

      // Reset and sequential fetch
      cyc(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      settle();
      chk("reset_pc", bus.pc, 16'h0000);
      chk("reset_instr", bus.if_id_instr, 16'hFFFF);
      chk("reset_valid", {15'd0, bus.if_id_valid}, 16'h0000);
      for (int i = 0; i < 4; i++) norm();
      settle();
      chk("seq_pc", bus.pc, 16'h0004);
      chk("seq_instr", bus.if_id_instr, 16'h1003);
      chk("seq_valid", {15'd0, bus.if_id_valid}, 16'h0001);

      // BEQ backwards from if_id_pc=5, kill held through the bubble
      norm(); norm();
      redir(OP_BEQ, 16'hFFFD, 16'h0000, 1'b0);
      settle();
      chk("beq_pc", bus.pc, 16'h0002);
      chk("beq_bubble", bus.if_id_instr, 16'hFFFF);
      redir(OP_BEQ, 16'hFFFD, 16'h0000, 1'b0);
      settle();
      chk("held_kill_pc", bus.pc, 16'h0003);

      // CALL from if_id_pc=10 to 40, RET from 42 back to 11
      for (int i = 0; i < 8; i++) norm();
      redir(OP_CALL, 16'h0000, 16'd40, 1'b0);
      settle();
      chk("call_pc", bus.pc, 16'd40);
      norm(); norm(); norm();
      redir(OP_RET, 16'h0000, 16'h0000, 1'b0);
      settle();
      chk("ret_pc", bus.pc, 16'd11);

      // Nine CALLs overflow an 8-deep stack, nine RETs then underflow
      for (int i = 0; i < 9; i++) begin
         norm();
         redir(OP_CALL, 16'h0000, 16'h0200 + 16'(i * 16), 1'b0);
      end
      settle();
      chk("ovf_set", {15'd0, bus.ras_overflow}, 16'h0001);
      norm();
      redir(OP_RET, 16'h0000, 16'h0000, 1'b0);
      settle();
      chk("ret_lifo_first", bus.pc, 16'h0261);
      for (int i = 0; i < 7; i++) begin
         norm();
         redir(OP_RET, 16'h0000, 16'h0000, 1'b0);
      end
      settle();
      chk("ret_lifo_last", bus.pc, 16'd12);
      norm();
      redir(OP_RET, 16'h0000, 16'h0000, 1'b0);
      settle();
      chk("unf_set", {15'd0, bus.ras_underflow}, 16'h0001);
      chk("unf_fallthrough", bus.pc, 16'd13);

      // Redirect overrides stall, then plain stall freezes everything
      norm();
      redir(OP_JMP, 16'h0000, 16'h0100, 1'b1);
      settle();
      chk("stall_jmp_pc", bus.pc, 16'h0100);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
      settle();
      chk("stall_hold_pc", bus.pc, 16'h0100);
      chk("stall_hold_valid", {15'd0, bus.if_id_valid}, 16'h0000);

      // Reset alongside a CALL kill discards the push
      norm();
      cyc(1'b1, 1'b1, OP_CALL, 16'h0000, 16'h0300, 16'h0000, 1'b0);
      settle();
      chk("rst_call_pc", bus.pc, 16'h0000);
      norm();
      redir(OP_RET, 16'h0000, 16'h0000, 1'b0);
      settle();
      chk("rst_no_push", {15'd0, bus.ras_underflow}, 16'h0001);

      // PC wraps from 16'hFFFF to 0
      norm();
      redir(OP_JMP, 16'h0000, 16'hFFFF, 1'b0);
      norm();
      settle();
      chk("wrap_pc", bus.pc, 16'h0000);
      chk("wrap_ipc", bus.if_id_pc, 16'hFFFF);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) op = 4'(8 + $urandom_range(0, 5));
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 40), op,
             16'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
      end

      @(negedge CLK);
      bus.kill = 1'b0;
      repeat (2) @(posedge CLK);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the decode-stage `kill` redirect produced for BEQ/BNE/JMP/CALL/RET/FOR.
- Owns the PC register, the IF/ID pipeline register and a small return-address stack (RAS).
- On a taken redirect it selects the new PC, squashes the wrong-path fetch into a bubble and pushes or pops return addresses for CALL/RET.
- Sits between instruction memory and the decode stage of the 16-bit pipeline.

Parameters:
- RAS_DEPTH, 8, number of return-address entries; must be a power of two, at least 2.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hFFFF, bubble encoding written into IF/ID on squash and reset.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  synchronous active-high reset.
- kill  input  1  redirect request from hazard unit for the instruction currently in ID.
- op_id  input  4  opcode of the instruction in ID, using shared opcode defines.
- imm_id  input  16  sign-extended branch offset of the ID instruction.
- jump_target  input  16  absolute target for JMP/CALL.
- for_target  input  16  loop-head address for FOR.
- stall  input  1  load-use stall; hold PC and IF/ID.
- instr_mem  input  16  instruction-memory read data at `pc`, combinational.
- pc  output  16  fetch address.
- if_id_instr  output  16  instruction latched for decode.
- if_id_pc  output  16  PC of `if_id_instr`.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- ras_overflow  output  1  sticky; CALL pushed while RAS full.
- ras_underflow  output  1  sticky; RET popped while RAS empty.

Behaviour:
- Reset, synchronous on CLK with RST=1:
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - RAS pointer=0 (empty); both sticky flags=0.
  - RST mid-redirect discards the pending push/pop.
- Effective redirect: `redir = kill & if_id_valid`. `kill` is ignored while ID holds a bubble, so one redirect yields exactly one squash.
- Next-PC select when `redir`:
  - BEQ/BNE: `if_id_pc + imm_id`, modulo 2^16.
  - JMP: `jump_target`.
  - CALL: `jump_target`; push `if_id_pc + 1`.
  - RET: RAS top; pop.
  - FOR: `for_target`.
  - Any other op with `redir`: `if_id_pc + 1`, with no stack effect.
- Redirect cycle: `pc` <= target; `if_id_instr` <= NOP_INSTR; `if_id_valid` <= 0.
  - The wrong-path fetch at the old `pc` is dropped.
  - Redirect penalty is exactly one bubble.
- Priority: RST > redir > stall > normal.
  - A redirect overrides a simultaneous stall.
- Stall without redirect: `pc`, `if_id_*` and the RAS all hold.
- Normal cycle:
  - `pc` <= `pc + 1` (wraps 16'hFFFF -> 0).
  - `if_id_instr` <= `instr_mem`, `if_id_pc` <= `pc`, `if_id_valid` <= 1.
- RAS is a LIFO with `RAS_DEPTH` entries and a count 0..RAS_DEPTH.
  - Push when full: entry not written, count unchanged, `ras_overflow` <= 1; redirect still happens.
  - Pop when empty: target = `if_id_pc + 1` (fall through), count unchanged, `ras_underflow` <= 1.
  - Sticky flags clear only on RST.
- Only one push or pop occurs per cycle, so there is no simultaneous push/pop case.
- `pc` is a pure register output and has no combinational path from `kill`.

Decomposition:
- Shared package/include: opcode defines (BEQ, BNE, JMP, CALL, RET, FOR), NOP_INSTR encoding, 16-bit word width constant.
- Sub-module `return_addr_stack`:
  - Inputs: CLK, RST, push, pop, push_data.
  - Outputs: top, full, empty.
  - Parameter: DEPTH.
- Next-PC mux and IF/ID register stay in the top module.

Test Plan:
- Reset then run 4 cycles with instr_mem=16'h1000+pc -> pc 0,1,2,3,4; if_id_instr 16'h1000..16'h1003; if_id_valid 0 then 1.
- BEQ at if_id_pc=5, imm_id=16'hFFFD, kill=1 -> next pc=2; if_id_instr=16'hFFFF, valid=0; kill held high in the bubble cycle causes no second redirect.
- CALL at pc 10, jump_target=40, then RET at pc 42 -> pc=40 after CALL and pc=11 after RET; RAS empty afterwards.
- Nine CALLs with RAS_DEPTH=8 -> ras_overflow=1 on the 9th; next 8 RETs return the 8 pushed addresses in LIFO order; 9th RET sets ras_underflow=1 and falls through to if_id_pc+1.
- stall=1 and kill=1 (JMP, jump_target=16'h0100) together -> pc=16'h0100, bubble inserted; stall alone for 3 cycles -> pc and if_id_* frozen.
- RST asserted in the same cycle as CALL kill -> pc=RESET_PC, RAS empty, no push recorded; pc=16'hFFFF normal fetch -> wraps to 0.
